// File: rtl/cache_pkg.sv
// ============================================================================
// cache_pkg : shared address layout, line geometry and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int c_WORD_W     = 32;
    localparam int c_LINE_W     = 2 * c_WORD_W;
    localparam int c_OFFSET_BIT = 2;
    localparam int c_INDEX_LO   = 3;
    localparam int c_INDEX_HI   = 8;
    localparam int c_TAG_LO     = 9;
    localparam int c_TAG_HI     = 18;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_FILL0 = 3'd1;
    localparam state_t c_ST_FILL1 = 3'd2;
    localparam state_t c_ST_WRITE = 3'd3;
    localparam state_t c_ST_DONE  = 3'd4;

    function automatic logic [c_WORD_W-1:0] f_sel_word(
        input logic [c_LINE_W-1:0] line,
        input logic                sel
    );
        return sel ? line[c_LINE_W-1:c_WORD_W] : line[c_WORD_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_storage.sv
// ============================================================================
// cache_storage : two-way tag/valid/data arrays, async read, sync writes
// Rev 1.0
// ============================================================================
`default_nettype none

module cache_storage
    import cache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int TAG_W = 10,
    parameter int IDX_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_W-1:0]    i_rd_idx,
    output logic [1:0]          o_valid,
    output logic [TAG_W-1:0]    o_tag0,
    output logic [TAG_W-1:0]    o_tag1,
    output logic [c_LINE_W-1:0] o_line0,
    output logic [c_LINE_W-1:0] o_line1,
    input  logic                i_line_we,
    input  logic                i_line_way,
    input  logic [IDX_W-1:0]    i_line_idx,
    input  logic [TAG_W-1:0]    i_line_tag,
    input  logic [c_LINE_W-1:0] i_line_data,
    input  logic                i_word_we,
    input  logic                i_word_way,
    input  logic [IDX_W-1:0]    i_word_idx,
    input  logic                i_word_sel,
    input  logic [c_WORD_W-1:0] i_word_data
);

    logic [SETS-1:0]     r_valid [2];
    logic [TAG_W-1:0]    r_tag   [2][SETS];
    logic [c_LINE_W-1:0] r_data  [2][SETS];

    assign o_valid = {r_valid[1][i_rd_idx], r_valid[0][i_rd_idx]};
    assign o_tag0  = r_tag[0][i_rd_idx];
    assign o_tag1  = r_tag[1][i_rd_idx];
    assign o_line0 = r_data[0][i_rd_idx];
    assign o_line1 = r_data[1][i_rd_idx];

    // Only the valid bits are reset; tag and data are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid[0] <= '0;
            r_valid[1] <= '0;
        end else if (i_line_we) begin
            r_valid[i_line_way][i_line_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_line_we) begin
            r_tag[i_line_way][i_line_idx]  <= i_line_tag;
            r_data[i_line_way][i_line_idx] <= i_line_data;
        end
        if (i_word_we) begin
            if (i_word_sel) begin
                r_data[i_word_way][i_word_idx][c_LINE_W-1:c_WORD_W] <= i_word_data;
            end else begin
                r_data[i_word_way][i_word_idx][c_WORD_W-1:0] <= i_word_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_controller.sv
// ============================================================================
// cache_controller : 2-way write-through, no-write-allocate cache with LRU
// Rev 1.0
// ============================================================================
`default_nettype none

module cache_controller
    import cache_pkg::*;
#(
    parameter int SETS  = 1 << (c_INDEX_HI - c_INDEX_LO + 1),
    parameter int TAG_W = c_TAG_HI - c_TAG_LO + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdEn,
    input  logic        wrEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        sram_rdEn,
    output logic        sram_wrEn,
    output logic [31:0] sram_address,
    output logic [31:0] sram_writeData,
    input  logic [31:0] sram_readData,
    input  logic        sram_ready
);

    localparam int IDX_W = $clog2(SETS);

    logic [IDX_W-1:0]    w_index;
    logic [TAG_W-1:0]    w_tag;
    logic                w_offset;
    logic [1:0]          w_valid;
    logic [TAG_W-1:0]    w_tag0;
    logic [TAG_W-1:0]    w_tag1;
    logic [c_LINE_W-1:0] w_line0;
    logic [c_LINE_W-1:0] w_line1;
    logic                w_hit0;
    logic                w_hit1;
    logic                w_hit;
    logic                w_hit_way;
    logic [c_WORD_W-1:0] w_hit_word;
    logic                w_victim;
    logic                w_fill_done;
    logic                w_line_we;
    logic                w_word_we;
    logic                w_rd_hit;
    state_t              w_next;

    state_t              r_state;
    logic [SETS-1:0]     r_lru;
    logic [c_WORD_W-1:0] r_word0;
    logic [c_WORD_W-1:0] r_done_data;

    assign w_index  = address[c_INDEX_LO +: IDX_W];
    assign w_tag    = address[c_INDEX_LO + IDX_W +: TAG_W];
    assign w_offset = address[c_OFFSET_BIT];

    assign w_hit0     = w_valid[0] && (w_tag0 == w_tag);
    assign w_hit1     = w_valid[1] && (w_tag1 == w_tag);
    assign w_hit      = w_hit0 || w_hit1;
    assign w_hit_way  = !w_hit0;
    assign w_hit_word = f_sel_word(w_hit0 ? w_line0 : w_line1, w_offset);

    // r_lru holds the way to evict next; empty ways are always filled first.
    assign w_victim = !w_valid[0] ? 1'b0 :
                      !w_valid[1] ? 1'b1 : r_lru[w_index];

    assign w_fill_done = (r_state == c_ST_FILL1) && sram_ready;
    assign w_line_we   = rst && w_fill_done;
    assign w_word_we   = rst && (r_state == c_ST_IDLE) && wrEn && w_hit;
    assign w_rd_hit    = (r_state == c_ST_IDLE) && rdEn && !wrEn && w_hit;

    cache_storage #(
        .SETS  (SETS),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_storage (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx    (w_index),
        .o_valid     (w_valid),
        .o_tag0      (w_tag0),
        .o_tag1      (w_tag1),
        .o_line0     (w_line0),
        .o_line1     (w_line1),
        .i_line_we   (w_line_we),
        .i_line_way  (w_victim),
        .i_line_idx  (w_index),
        .i_line_tag  (w_tag),
        .i_line_data ({sram_readData, r_word0}),
        .i_word_we   (w_word_we),
        .i_word_way  (w_hit_way),
        .i_word_idx  (w_index),
        .i_word_sel  (w_offset),
        .i_word_data (writeData)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (wrEn) begin
                    w_next = c_ST_WRITE;
                end else if (rdEn && !w_hit) begin
                    w_next = c_ST_FILL0;
                end
            end
            c_ST_FILL0: if (sram_ready) w_next = c_ST_FILL1;
            c_ST_FILL1: if (sram_ready) w_next = c_ST_DONE;
            c_ST_WRITE: if (sram_ready) w_next = c_ST_DONE;
            c_ST_DONE:  w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lru       <= '0;
            r_word0     <= '0;
            r_done_data <= '0;
        end else begin
            if ((r_state == c_ST_FILL0) && sram_ready) begin
                r_word0 <= sram_readData;
            end
            if (w_fill_done) begin
                r_lru[w_index] <= !w_victim;
                r_done_data    <= w_offset ? sram_readData : r_word0;
            end
            if ((r_state == c_ST_WRITE) && sram_ready) begin
                r_done_data <= '0;
            end
            if (w_rd_hit || w_word_we) begin
                r_lru[w_index] <= !w_hit_way;
            end
        end
    end

    always_comb begin
        ready          = 1'b0;
        readData       = '0;
        sram_rdEn      = 1'b0;
        sram_wrEn      = 1'b0;
        sram_address   = '0;
        sram_writeData = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (wrEn) begin
                    ready = 1'b0;
                end else if (rdEn) begin
                    ready    = w_hit;
                    readData = w_hit ? w_hit_word : '0;
                end else begin
                    ready = 1'b1;
                end
            end
            c_ST_FILL0: begin
                sram_rdEn    = 1'b1;
                sram_address = {address[31:3], 3'b000};
            end
            c_ST_FILL1: begin
                sram_rdEn    = 1'b1;
                sram_address = {address[31:3], 3'b100};
            end
            c_ST_WRITE: begin
                sram_wrEn      = 1'b1;
                sram_address   = address;
                sram_writeData = writeData;
            end
            c_ST_DONE: begin
                ready    = 1'b1;
                readData = r_done_data;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
// ============================================================================
// tb_cache_controller : scoreboard bench with a variable-latency SRAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdEn;
    logic        wrEn;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    logic        sram_rdEn;
    logic        sram_wrEn;
    logic [31:0] sram_address;
    logic [31:0] sram_writeData;
    logic [31:0] sram_readData;
    logic        sram_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];
    logic [31:0] ref_mem  [int unsigned];
    logic [31:0] sram_mem [int unsigned];

    int n_sram_rd = 0;
    int n_sram_wr = 0;
    int n_both    = 0;
    int lat_sum   = 0;
    int lat_cur   = 1;
    int sram_cnt  = 0;
    int fixed_lat = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk            (clk),
        .rst            (rst),
        .rdEn           (rdEn),
        .wrEn           (wrEn),
        .address        (address),
        .writeData      (writeData),
        .readData       (readData),
        .ready          (ready),
        .sram_rdEn      (sram_rdEn),
        .sram_wrEn      (sram_wrEn),
        .sram_address   (sram_address),
        .sram_writeData (sram_writeData),
        .sram_readData  (sram_readData),
        .sram_ready     (sram_ready)
    );

    function automatic logic [31:0] mem_dflt(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'hAAAA_0000;
            32'h0000_0104: return 32'hBBBB_0004;
            default:       return a ^ 32'h5EED_0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'h3;
        return ref_mem.exists(k) ? ref_mem[k] : mem_dflt(k);
    endfunction

    // SRAM model: access completes after 1..3 cycles of sustained request.
    always @(negedge clk) begin
        logic [31:0] k;
        k = sram_address & ~32'h3;
        if (sram_rdEn && sram_wrEn) n_both++;
        if (sram_rdEn || sram_wrEn) begin
            if (sram_cnt == 0) lat_cur = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
            sram_cnt++;
            if (sram_cnt >= lat_cur) begin
                sram_ready = 1'b1;
                sram_cnt   = 0;
                lat_sum   += lat_cur;
                if (sram_wrEn) begin
                    sram_mem[k]   = sram_writeData;
                    sram_readData = 32'hFFFF_FFFF;
                    n_sram_wr++;
                end else begin
                    sram_readData = sram_mem.exists(k) ? sram_mem[k] : mem_dflt(k);
                    n_sram_rd++;
                end
            end else begin
                sram_ready    = 1'b0;
                sram_readData = 32'hFFFF_FFFF;
            end
        end else begin
            sram_ready    = 1'b0;
            sram_readData = 32'hFFFF_FFFF;
            sram_cnt      = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // hitmode: 0 = must miss, 1 = must hit, 2 = either (inferred from SRAM traffic)
    task automatic xact(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input int hitmode, input string tag);
        int cyc, rd0, wr0, lat0, stall;
        bit is_hit;
        rdEn = rd; wrEn = wr; address = a; writeData = wd;
        if (wr) begin
            exp_q.push_back(32'h0);
            ref_mem[a & ~32'h3] = wd;
        end else begin
            exp_q.push_back(ref_rd(a));
        end
        rd0 = n_sram_rd; wr0 = n_sram_wr; lat0 = lat_sum;
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
        end while (!ready && cyc < 64);
        if (!ready) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        stall = cyc - 1;
        check_eq({tag, "_data"}, readData, exp_q.pop_front());
        if (wr) begin
            check_eq({tag, "_wr_stall"}, stall, lat_sum - lat0 + 1);
            check_eq({tag, "_wr_nrd"}, n_sram_rd - rd0, 0);
            check_eq({tag, "_wr_nwr"}, n_sram_wr - wr0, 1);
        end else begin
            is_hit = (hitmode == 1) || (hitmode == 2 && n_sram_rd == rd0);
            if (is_hit) begin
                check_eq({tag, "_hit_stall"}, stall, 0);
                check_eq({tag, "_hit_nrd"}, n_sram_rd - rd0, 0);
            end else begin
                check_eq({tag, "_miss_stall"}, stall, lat_sum - lat0 + 1);
                check_eq({tag, "_miss_nrd"}, n_sram_rd - rd0, 2);
            end
            check_eq({tag, "_rd_nwr"}, n_sram_wr - wr0, 0);
        end
        @(posedge clk); #1;
        rdEn = 1'b0; wrEn = 1'b0;
    endtask

    initial begin
        logic [31:0] raddr [6];
        int cyc, rd0;
        raddr = '{32'h000, 32'h200, 32'h400, 32'h600, 32'h008, 32'h10C};
        rst = 1'b0; rdEn = 1'b0; wrEn = 1'b0; address = '0; writeData = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_eq("rst_ready", ready, 1);
        check_eq("rst_rdata", readData, 0);
        check_eq("rst_sram_rd", sram_rdEn, 0);
        check_eq("rst_sram_wr", sram_wrEn, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        check_eq("idle_ready", ready, 1);
        check_eq("idle_rdata", readData, 0);
        @(posedge clk); #1;

        xact(1, 0, 32'h104, 0, 0, "cold_104");
        xact(1, 0, 32'h104, 0, 1, "rehit_104");
        xact(1, 0, 32'h100, 0, 1, "hit_100");

        xact(1, 0, 32'h000, 0, 0, "lru_000");
        xact(1, 0, 32'h200, 0, 0, "lru_200");
        xact(1, 0, 32'h400, 0, 0, "lru_400");
        xact(1, 0, 32'h200, 0, 1, "lru_200_hit");
        xact(1, 0, 32'h000, 0, 0, "lru_000_evicted");

        xact(0, 1, 32'h104, 32'hDEADBEEF, 0, "wr_hit_104");
        check_eq("wr_hit_sram", sram_mem[32'h104], 32'hDEADBEEF);
        xact(1, 0, 32'h104, 0, 1, "rd_after_wr_104");

        xact(0, 1, 32'h608, 32'h12345678, 0, "wr_miss_608");
        xact(1, 0, 32'h608, 0, 0, "rd_608_miss");

        xact(1, 1, 32'h104, 32'h0BADF00D, 0, "rdwr_104");
        xact(1, 0, 32'h104, 0, 1, "rd_after_rdwr");

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = raddr[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) xact(0, 1, a, $urandom, 2, "rnd_wr");
            else                           xact(1, 0, a, 0, 2, "rnd_rd");
        end

        fixed_lat = 3;
        rdEn = 1'b1; address = 32'h2A0;
        rd0 = n_sram_rd; cyc = 0;
        while (n_sram_rd == rd0 && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        check_eq("rst_fill0_done", (cyc < 50), 1);
        @(negedge clk); #1;
        check_eq("fill1_addr", sram_address, 32'h2A4);
        check_eq("fill1_rden", sram_rdEn, 1);
        rst = 1'b0; rdEn = 1'b0;
        @(negedge clk); #1;
        check_eq("midrst_ready", ready, 1);
        check_eq("midrst_rdata", readData, 0);
        check_eq("midrst_sram_rd", sram_rdEn, 0);
        rst = 1'b1;
        fixed_lat = 0;
        @(posedge clk); #1;
        xact(1, 0, 32'h2A0, 0, 0, "midrst_reread");
        xact(1, 0, 32'h104, 0, 0, "midrst_104_cleared");

        check_eq("never_both_en", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have CPU-side ports: rdEn in 1 (load request); wrEn in 1 (store request); address in 32 (byte address); writeData in 32 (store word).
REQ-004 SHALL have CPU-side outputs: readData out 32 (load result); ready out 1 (1 = request complete or no request pending; 0 = CPU must freeze).
REQ-005 SHALL have SRAM-side ports: sram_rdEn out 1; sram_wrEn out 1; sram_address out 32; sram_writeData out 32; sram_readData in 32; sram_ready in 1 (high in the cycle an SRAM access completes).
REQ-006 SHALL use parameters SETS default 64 (number of sets) and TAG_W default 10 (tag width).

Function
REQ-007 SHALL be 2-way set-associative, 2 words per line, write-through, no-write-allocate, 1 LRU bit per set.
REQ-008 SHALL decode address as: [1:0] ignored, [2] word offset, [8:3] index, [18:9] tag; bits [31:19] ignored.
REQ-009 SHALL evaluate a hit combinationally: valid and tag match in either way of the indexed set.
REQ-010 SHALL implement FSM states IDLE, FILL0, FILL1, WRITE, DONE.
REQ-011 Read hit in IDLE SHALL drive readData with the addressed word and ready=1 in the same cycle, stay in IDLE, and set LRU to the other way.
REQ-012 Read miss in IDLE SHALL drive ready=0 and go to FILL0.
REQ-013 FILL0 SHALL hold sram_rdEn=1 with sram_address={address[31:3],3'b000} until sram_ready=1, latch sram_readData as word0, then go to FILL1.
REQ-014 FILL1 SHALL hold sram_rdEn=1 with sram_address={address[31:3],3'b100} until sram_ready=1, latch word1, write the line, tag, and valid=1 into the victim way, set LRU to the other way, then go to DONE.
REQ-015 The victim SHALL be way0 if invalid, else way1 if invalid, else the way indicated by the LRU bit.
REQ-016 A write in IDLE SHALL go to WRITE with ready=0; on a hit it SHALL update the cached word in that cycle and set LRU; a miss SHALL leave the cache unchanged.
REQ-017 WRITE SHALL hold sram_wrEn=1 with sram_address=address and sram_writeData=writeData until sram_ready=1, then go to DONE.
REQ-018 DONE SHALL drive ready=1 for exactly one cycle, with readData set to the filled word selected by address[2] after a fill and 0 after a write, then go to IDLE.
REQ-019 Outside FILL0/FILL1/WRITE, sram_rdEn and sram_wrEn SHALL be 0; they SHALL never both be 1.
REQ-020 The CPU SHALL hold address/writeData/rdEn/wrEn stable while ready=0; the block SHALL NOT re-latch them.
REQ-021 If rdEn and wrEn are both 1, the request SHALL be treated as a write.
REQ-022 In IDLE with no request, ready SHALL be 1 and readData 0.
REQ-023 Fill latency (cycles with ready=0) SHALL be (SRAM latency word0)+(SRAM latency word1)+1; a write SHALL take SRAM latency+1.

Reset
REQ-024 When rst=0 at a clock edge, the FSM SHALL go to IDLE and all valid and LRU bits SHALL clear; the next cycle SHALL show ready=1, readData=0, sram_rdEn=0, and sram_wrEn=0.
REQ-025 Reset during FILL or WRITE SHALL abandon the access, with no partial line marked valid.
REQ-026 Data and tag arrays SHALL NOT require reset.

Structure
REQ-027 State encoding, the address field bounds, and the line width SHALL reside in shared package cache_pkg.
REQ-028 Tag/valid/data arrays SHALL be in sub-module cache_storage (2 ways; combinational read; synchronous line-write and word-write ports); the FSM, LRU, and victim logic SHALL stay in cache_controller.

Verification
REQ-029 Cold read 0x0000_0104 with SRAM returning 0xAAAA0000 (at 0x100) and 0xBBBB0004 (at 0x104) SHALL give DONE readData=0xBBBB0004, then an immediate re-read SHALL hit with ready=1 in the same cycle and no SRAM access.
REQ-030 Reading 0x000, then 0x200, then 0x400 (same set, different tags) SHALL cause the third fill to evict the 0x000 line (LRU), so that reading 0x200 hits and reading 0x000 misses.
REQ-031 Write 0xDEADBEEF to cached 0x104 SHALL issue one SRAM write with ready=0 until sram_ready, and a subsequent read SHALL hit and return 0xDEADBEEF.
REQ-032 Write to uncached 0x608 SHALL issue an SRAM write only, and a subsequent read of 0x608 SHALL miss and fill.
REQ-033 Asserting rst=0 in FILL1 SHALL give IDLE with ready=1 next cycle, and a re-read of the same address SHALL miss.
REQ-034 rdEn=wrEn=1 SHALL assert sram_wrEn only, with sram_rdEn=0 throughout.
